// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage data-access unit of the 5-stage RV32I pipeline.
// Builds the word-aligned cache request, byte masks and lane-shifted store
// data from the effective address, runs the request/response handshake with
// the data cache, and holds the raw loaded word for capture into MEM/WB.
//
// Build option: define MEM_MISALIGN_TRAP_EN to raise trap on misaligned
// halfword/word accesses and suppress their request. Without it trap is 0
// and misaligned accesses issue with masks truncated to the current word.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_data,
  input  logic        pipe_advance,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_rdata,
  output logic [31:0] addr_aligned,
  output logic [1:0]  bit_shift,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] write_data,
  output logic        trap,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  size_mask;
  logic        is_mem;
  logic        need_access;
  logic        req_active;
  logic        stall_fsm;

  assign addr_aligned = {alu_res[31:2], 2'b00};
  assign bit_shift    = alu_res[1:0];
  assign is_mem       = valid_in & (is_load | is_store);

  // Byte-lane mask for the access width, shifted to the addressed lane.
  always_comb begin
    // NOTE: defaults first so every path assigns the output and no latch is inferred.
    size_mask = 4'b0000;
    case (funct3)
      3'b000, 3'b100: size_mask = 4'b0001 << bit_shift;
      3'b001, 3'b101: size_mask = 4'b0011 << bit_shift;
      3'b010:         size_mask = 4'b1111;
      default:        size_mask = 4'b0000;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned halfword (odd address) or word (any low bit set) traps.
  always_comb begin
    trap = 1'b0;
    if (is_mem) begin
      case (funct3)
        3'b001, 3'b101: trap = bit_shift[0];
        3'b010:         trap = (bit_shift != 2'b00);
        default:        trap = 1'b0;
      endcase
    end
  end
`else
  assign trap = 1'b0;
`endif

  assign need_access = is_mem & ~trap;
  assign req_active  = need_access & (state != DONE);

  assign rmask      = (need_access & is_load)  ? size_mask : 4'b0000;
  assign wmask      = (need_access & is_store) ? size_mask : 4'b0000;
  assign write_data = rs2_data << {bit_shift, 3'b000};

  assign dmem_addr  = addr_aligned;
  assign dmem_wmask = wmask;
  assign dmem_wdata = write_data;

  // Request strobes and stall are squashed while reset is asserted.
  assign dmem_read  = ~rst & req_active & is_load;
  assign dmem_write = ~rst & req_active & is_store;
  assign stall      = ~rst & stall_fsm;

  // Next-state and stall for the IDLE -> BUSY -> DONE access sequence.
  always_comb begin
    state_nxt = state;
    stall_fsm = 1'b0;
    case (state)
      IDLE: begin
        if (need_access) begin
          stall_fsm = 1'b1;
          state_nxt = dmem_resp ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_fsm = 1'b1;
        if (dmem_resp) state_nxt = DONE;
      end
      DONE: begin
        if (pipe_advance) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and load-data capture on the completing response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      mem_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      if (req_active && is_load && dmem_resp) mem_rdata <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of combinational vectors run through a
// full access each, plus hand-written multi-cycle sequences (latency, store,
// zero-latency response, DONE hold, back-to-back issue, reset in BUSY).
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_res, rs2_data;
  logic        pipe_advance, dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata, mem_rdata, addr_aligned, write_data;
  logic [3:0]  dmem_wmask, rmask, wmask;
  logic [1:0]  bit_shift;
  logic        trap, stall;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .alu_res(alu_res),
    .rs2_data(rs2_data), .pipe_advance(pipe_advance), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .mem_rdata(mem_rdata), .addr_aligned(addr_aligned), .bit_shift(bit_shift),
    .rmask(rmask), .wmask(wmask), .write_data(write_data), .trap(trap),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        valid;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [3:0]  mask;   // lane mask of the op if it issues
    logic        mis;    // traps when the trap option is built in
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete the access in progress and return the FSM to IDLE.
  task automatic retire();
    dmem_resp = 1'b1;
    tick();
    dmem_resp    = 1'b0;
    valid_in     = 1'b0;
    pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;
  endtask

  initial begin
    logic       e_trap, e_need;
    logic [3:0] e_rmask, e_wmask;
    int         n_rd, n_wr, n_st;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0000_0000, 4'b1111, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 1'b0, 32'hA500_0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1111_2222, 4'b1100, 1'b0, 32'h2222_0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0000_0001, 4'b1111, 1'b1, 32'h0000_0100};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_4001, 32'h0000_1234, 4'b0110, 1'b1, 32'h0012_3400};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_5002, 32'h0000_00FF, 4'b0100, 1'b0, 32'h00FF_0000};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_BABE, 4'b1111, 1'b0, 32'hCAFE_BABE};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_7003, 32'h0000_BEEF, 4'b1000, 1'b1, 32'hEF00_0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_8000, 32'h1234_5678, 4'b1111, 1'b0, 32'h1234_5678};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_9004, 32'h0000_0000, 4'b1111, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_A002, 32'h0000_00AB, 4'b1100, 1'b0, 32'h00AB_0000};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_B002, 32'h0000_ABCD, 4'b1111, 1'b1, 32'hABCD_0000};

    rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; alu_res = 32'h0; rs2_data = 32'h0;
    pipe_advance = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;

    // Reset: strobes forced low even with a load presented.
    tick();
    valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_res = 32'h100;
    @(negedge clk);
    check("rst_read", dmem_read, 1'b0);
    check("rst_stall", stall, 1'b0);
    tick();
    valid_in = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("idle_stall", stall, 1'b0);
    tick();

    // Table-driven: combinational outputs in IDLE, then retire the access.
    for (int i = 0; i < 12; i++) begin
      valid_in = vecs[i].valid; is_load = vecs[i].ld; is_store = vecs[i].st;
      funct3 = vecs[i].f3; alu_res = vecs[i].addr; rs2_data = vecs[i].rs2;
      dmem_rdata = 32'h0;
      e_trap  = TRAP_ON & vecs[i].mis & vecs[i].valid & (vecs[i].ld | vecs[i].st);
      e_need  = vecs[i].valid & (vecs[i].ld | vecs[i].st) & ~e_trap;
      e_rmask = (e_need & vecs[i].ld) ? vecs[i].mask : 4'b0000;
      e_wmask = (e_need & vecs[i].st) ? vecs[i].mask : 4'b0000;
      @(negedge clk);
      check($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_aligned", i), addr_aligned, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_shift", i), bit_shift, vecs[i].addr[1:0]);
      check($sformatf("v%0d_rmask", i), rmask, e_rmask);
      check($sformatf("v%0d_wmask", i), wmask, e_wmask);
      check($sformatf("v%0d_dmem_wmask", i), dmem_wmask, e_wmask);
      check($sformatf("v%0d_wdata", i), write_data, vecs[i].wdata);
      check($sformatf("v%0d_dmem_wdata", i), dmem_wdata, vecs[i].wdata);
      check($sformatf("v%0d_trap", i), trap, e_trap);
      check($sformatf("v%0d_stall", i), stall, e_need);
      check($sformatf("v%0d_read", i), dmem_read, e_need & vecs[i].ld);
      check($sformatf("v%0d_write", i), dmem_write, e_need & vecs[i].st);
      if (e_need) retire();
      else begin
        tick();
        valid_in = 1'b0;
      end
    end

    // LW 0x1000, response 3 cycles after the request, then hold DONE.
    valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    alu_res = 32'h1000; rs2_data = 32'h0; pipe_advance = 1'b0;
    n_rd = 0; n_st = 0;
    for (int c = 0; c < 8; c++) begin
      dmem_resp  = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      @(negedge clk);
      if (dmem_read) n_rd++;
      if (stall) n_st++;
      if (c == 0) check("lw_rmask", rmask, 4'b1111);
      if (c == 4) check("lw_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
      tick();
    end
    check("lw_read_cycles", n_rd, 4);
    check("lw_stall_cycles", n_st, 4);
    check("done_hold_rdata", mem_rdata, 32'hDEAD_BEEF);
    pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0; alu_res = 32'h1004;
    @(negedge clk);
    check("b2b_stall", stall, 1'b1);
    check("b2b_read", dmem_read, 1'b1);
    check("b2b_addr", dmem_addr, 32'h1004);
    dmem_resp = 1'b1; dmem_rdata = 32'h1122_3344;
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    check("b2b_mem_rdata", mem_rdata, 32'h1122_3344);
    check("b2b_done_stall", stall, 1'b0);
    valid_in = 1'b0; pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;

    // SB 0x1003, response one cycle after the request.
    valid_in = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b000;
    alu_res = 32'h1003; rs2_data = 32'h0000_00A5;
    n_wr = 0;
    for (int c = 0; c < 3; c++) begin
      dmem_resp  = (c == 1);
      dmem_rdata = 32'hBADB_AD00;
      @(negedge clk);
      if (dmem_write) n_wr++;
      if (c == 0) begin
        check("sb_wmask", dmem_wmask, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hA500_0000);
        check("sb_addr", dmem_addr, 32'h1000);
        check("sb_rmask", rmask, 4'b0000);
      end
      tick();
    end
    check("sb_write_cycles", n_wr, 2);
    check("sb_mem_rdata", mem_rdata, 32'h1122_3344);
    dmem_resp = 1'b0; valid_in = 1'b0; pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;

    // LH 0x2002, response in the request cycle.
    valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b001;
    alu_res = 32'h2002; rs2_data = 32'h0;
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA_0000;
    @(negedge clk);
    check("lh_stall", stall, 1'b1);
    check("lh_rmask", rmask, 4'b1100);
    check("lh_shift", bit_shift, 2'd2);
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    check("lh_done_stall", stall, 1'b0);
    check("lh_done_read", dmem_read, 1'b0);
    check("lh_mem_rdata", mem_rdata, 32'h55AA_0000);
    valid_in = 1'b0; pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;

    // Reset asserted while BUSY.
    valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_res = 32'h4000;
    tick();
    @(negedge clk);
    check("busy_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    check("rstbusy_read", dmem_read, 1'b0);
    check("rstbusy_stall", stall, 1'b0);
    tick();
    @(negedge clk);
    check("rstbusy_mem_rdata", mem_rdata, 32'h0);
    check("rstbusy_stall2", stall, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle_read", dmem_read, 1'b1);
    check("post_rst_idle_stall", stall, 1'b1);
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
